// File: rtl/add_sub_ctrl.sv
// add_sub_ctrl: request/response front end for an external registered ADD_SUB
// unit. Accepted operands are registered onto a0/b0/doAdd0, tracked through
// a two-stage in-flight pipeline, and the returning result0 is captured into
// a DEPTH-entry result FIFO that drives the rsp_* handshake.
// Credits are counted over FIFO entries plus in-flight requests, so a result
// always has a FIFO slot waiting for it by the time it arrives.
// Optional feature: define ADDSUB_CTRL_STATS_EN to add the add_cnt/sub_cnt
// accepted-request counters and their ports.
module add_sub_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_add,
  output logic [7:0] a0,
  output logic [7:0] b0,
  output logic       doAdd0,
  input  logic [8:0] result0,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_result,
  output logic       rsp_add
`ifdef ADDSUB_CTRL_STATS_EN
  ,
  output logic [15:0] add_cnt,
  output logic [15:0] sub_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   OCC_LIM  = (CW + 1)'(DEPTH);

  logic [8:0]    mem_res [DEPTH];
  logic          mem_add [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // inf_v[0]: issued this cycle (ADD_SUB samples next edge)
  // inf_v[1]: ADD_SUB has sampled; result0 is valid and is pushed next edge
  logic [1:0]    inf_v;
  logic [1:0]    inf_op;

  logic [1:0]    inflight_cnt;
  logic [CW:0]   occ;
  logic          accept;
  logic          push;
  logic          pop;

  assign inflight_cnt = {1'b0, inf_v[0]} + {1'b0, inf_v[1]};
  assign occ          = {1'b0, count} + {{(CW-1){1'b0}}, inflight_cnt};

  // Ready depends only on registered occupancy (plus reset), never on rsp_ready.
  assign req_ready  = !rst && (occ < OCC_LIM);
  assign rsp_valid  = !rst && (count != '0);
  assign accept     = req_valid && req_ready;
  assign push       = inf_v[1];
  assign pop        = rsp_valid && rsp_ready;
  assign rsp_result = mem_res[rd_ptr];
  assign rsp_add    = mem_add[rd_ptr];

  // Operand/opcode registers toward ADD_SUB; hold unless a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      a0     <= '0;
      b0     <= '0;
      doAdd0 <= 1'b0;
    end else if (accept) begin
      a0     <= req_a;
      b0     <= req_b;
      doAdd0 <= req_add;
    end
  end

  // In-flight tracker: the opcode travels with its request so the FIFO gets
  // the right echo even if doAdd0 has already moved on to a newer request.
  always_ff @(posedge clk) begin
    if (rst) begin
      inf_v  <= '0;
      inf_op <= '0;
    end else begin
      inf_v  <= {inf_v[0], accept};
      inf_op <= {inf_op[0], req_add};
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_ptr] <= result0;
      mem_add[wr_ptr] <= inf_op[1];
    end
  end

  // FIFO pointers and occupancy; power-of-two depth gives natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ADDSUB_CTRL_STATS_EN
  // Accepted-request statistics, free-running with wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_cnt <= '0;
      sub_cnt <= '0;
    end else if (accept) begin
      if (req_add) add_cnt <= add_cnt + 16'd1;
      else         sub_cnt <= sub_cnt + 16'd1;
    end
  end
`endif

  // The credit rule must make a push into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == DEPTH_C)))
    else $error("add_sub_ctrl: push into full result FIFO");

endmodule

// File: tb/tb_add_sub_ctrl.sv
// Testbench for add_sub_ctrl: a registered ADD_SUB stand-in, randomized
// requests, and a queue-based scoreboard with an independent monitor.
module tb_add_sub_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_add;
  logic [7:0] a0;
  logic [7:0] b0;
  logic       doAdd0;
  logic [8:0] result0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_result;
  logic       rsp_add;
`ifdef ADDSUB_CTRL_STATS_EN
  logic [15:0] add_cnt;
  logic [15:0] sub_cnt;
`endif

  add_sub_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_add    (req_add),
    .a0         (a0),
    .b0         (b0),
    .doAdd0     (doAdd0),
    .result0    (result0),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_add    (rsp_add)
`ifdef ADDSUB_CTRL_STATS_EN
    ,
    .add_cnt    (add_cnt),
    .sub_cnt    (sub_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Downstream ADD_SUB: one register stage from a0/b0/doAdd0 to result0.
  always @(posedge clk) begin
    if (rst) result0 <= '0;
    else     result0 <= doAdd0 ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a0} - {1'b0, b0});
  end

  int         n_vec = 0;
  int         n_bad = 0;
  logic [9:0] exp_q[$];
  int         exp_add = 0;
  int         exp_sub = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic reduced modulo 512.
  function automatic logic [9:0] model(input int a, input int b, input bit add);
    int r;
    r = add ? (a + b) : (a - b);
    r = ((r % 512) + 512) % 512;
    return {9'(r), add};
  endfunction

  // Offer one request until accepted or the cycle budget runs out.
  // Called and returns #1 after a rising edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic add,
                      input int budget, input bit must_ready, output bit ok);
    ok = 1'b0;
    req_a = a; req_b = b; req_add = add; req_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (must_ready) check("req_ready_sustained", req_ready, 1);
      if (req_ready) begin
        exp_q.push_back(model(int'(a), int'(b), add));
        if (add) exp_add++; else exp_sub++;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || rsp_valid) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_in_budget", (exp_q.size() == 0) ? 1 : 0, 1);
  endtask

  // Response monitor: pops the scoreboard on every handshake and checks
  // that a stalled response holds steady.
  logic [9:0] held;
  bit         held_v = 1'b0;
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && rsp_valid) check("rsp_stable", {rsp_result, rsp_add}, held);
      held_v = 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_unexpected: got 'h%0h, expected no response at %0t",
                   {rsp_result, rsp_add}, $time);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", {rsp_result, rsp_add}, e);
        end
      end else if (rsp_valid) begin
        held   = {rsp_result, rsp_add};
        held_v = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n_acc;

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_add = 1'b0; rsp_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_a0", a0, 0);
    check("rst_b0", b0, 0);
    check("rst_doAdd0", doAdd0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);
    @(posedge clk); #1;

    // Single add with latency check
    send(8'hFF, 8'h01, 1'b1, 4, 1'b1, ok);
    @(negedge clk); check("lat_add_e1", rsp_valid, 0);
    @(negedge clk); check("lat_add_e2", rsp_valid, 0);
    @(negedge clk); check("lat_add_e3", rsp_valid, 1);
    check("add_ff_01", {rsp_result, rsp_add}, {9'h100, 1'b1});
    wait_idle(20);
    check("hold_a0", a0, 8'hFF);
    check("hold_b0", b0, 8'h01);
    check("hold_doAdd0", doAdd0, 1);
    @(posedge clk); #1;

    // Subtract that wraps
    send(8'd3, 8'd5, 1'b0, 4, 1'b1, ok);
    @(negedge clk); check("lat_sub_e1", rsp_valid, 0);
    @(negedge clk); check("lat_sub_e2", rsp_valid, 0);
    @(negedge clk); check("lat_sub_e3", rsp_valid, 1);
    check("sub_3_5", {rsp_result, rsp_add}, {9'h1FE, 1'b0});
    wait_idle(20);
    @(posedge clk); #1;

    // 20 random back-to-back requests
    for (int i = 0; i < 20; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1, 1'b1, ok);
    wait_idle(40);
    @(posedge clk); #1;

    // Backpressure: only DEPTH requests fit while the consumer stalls
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 3, 1'b0, ok);
      if (ok) n_acc++;
    end
    begin
      logic [7:0] a5, b5, a6, b6;
      logic       o5, o6;
      a5 = 8'($urandom); b5 = 8'($urandom); o5 = 1'($urandom);
      a6 = 8'($urandom); b6 = 8'($urandom); o6 = 1'($urandom);
      send(a5, b5, o5, 4, 1'b0, ok);
      check("bp_accepted", n_acc, DEPTH);
      check("bp_fifth_blocked", ok, 0);
      @(negedge clk);
      check("bp_req_ready_low", req_ready, 0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      send(a5, b5, o5, 20, 1'b0, ok);
      check("bp_fifth_late", ok, 1);
      send(a6, b6, o6, 20, 1'b0, ok);
      check("bp_sixth_late", ok, 1);
    end
    wait_idle(40);
    @(posedge clk); #1;

    // Mid-operation reset: 1 buffered, 2 in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1, 1'b1, ok);
    rst = 1'b1;
    exp_q.delete();
    exp_add = 0;
    exp_sub = 0;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("postrst_req_ready", req_ready, 1);
    check("postrst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;

`ifdef ADDSUB_CTRL_STATS_EN
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'b1, 4, 1'b0, ok);
    for (int i = 0; i < 2; i++) send(8'($urandom), 8'($urandom), 1'b0, 4, 1'b0, ok);
    wait_idle(20);
    check("stat_add_cnt", add_cnt, 3);
    check("stat_sub_cnt", sub_cnt, 2);
    @(posedge clk); #1;
    while (exp_add < 65535) send(8'($urandom), 8'($urandom), 1'b1, 4, 1'b0, ok);
    wait_idle(20);
    check("stat_add_cnt_max", add_cnt, 16'hFFFF);
    @(posedge clk); #1;
    send(8'($urandom), 8'($urandom), 1'b1, 4, 1'b0, ok);
    wait_idle(20);
    check("stat_add_cnt_wrap", add_cnt, 0);
    check("stat_sub_cnt_final", sub_cnt, 16'(exp_sub));
    @(posedge clk); #1;
`endif

    // Final mixed traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(8'($urandom), 8'($urandom), 1'($urandom), 40, 1'b0, ok);
      end
      begin
        for (int i = 0; i < 80; i++) begin
          rsp_ready = 1'($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle(60);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
